uart_tx_frame: RTL and testbench

Parametrised UART transmitter that replaces the fixed 8N1, 115200-baud, run/feedback transmitter. Baud rate, data width, parity and stop-bit count are set per instance. Byte transfer uses a valid/ready handshake with a clock-enable baud tick, so no derived clock exists. It sits between the top-level command logic and the board TX pin, and runs entirely in the `clock_50mhz` domain.

---
 rtl/uart_tx_frame.sv | 200 ++++++++++++++++++++
 tb/tb_uart_tx_frame.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame.sv
// -----------------------------------------------------------------------------
// uart_tx_frame
//   Parametrised UART transmitter. It builds one frame per word: a start bit,
//   DATA_BITS payload bits sent LSB first, an optional parity bit and STOP_BITS
//   stop bits. Each bit lasts DIV clock cycles, where
//   DIV = round(CLK_FREQ / BAUD). The bit timer is a clock-enable counter, so
//   no derived clock is created.
//
//   Optional feature macro: UART_TX_FIFO_EN
//     defined   : a 2**FIFO_AW-entry FIFO buffers words between the handshake
//                 and the framer. Frames then go out back to back.
//     undefined : single-word operation. ready is high only while idle.
//
//   Ports
//     clock_50mhz  in   sole clock, rising edge
//     reset        in   asynchronous, active-high reset
//     data         in   payload word, LSB transmitted first
//     valid        in   data is offered
//     ready        out  word is accepted on a cycle with valid && ready
//     busy         out  a frame is on the line or a word is queued
//     done         out  one-cycle pulse in the last cycle of the last stop bit
//     tx_pin       out  serial line, idles high
//
//   The line, busy and done are registered, so they appear one cycle after
//   the framer state that produces them.
// -----------------------------------------------------------------------------
module uart_tx_frame #(
   parameter int CLK_FREQ  = 50_000_000,
   parameter int BAUD      = 115200,
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1,
   parameter int FIFO_AW   = 3
) (
   input  logic                 clock_50mhz,
   input  logic                 reset,
   input  logic [DATA_BITS-1:0] data,
   input  logic                 valid,
   output logic                 ready,
   output logic                 busy,
   output logic                 done,
   output logic                 tx_pin
);

   localparam int            DIV      = (CLK_FREQ + BAUD / 2) / BAUD;
   localparam int            CW       = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] TICK_VAL = CW'(DIV - 1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

   state_t               r_state, w_state_nxt;
   logic [CW-1:0]        r_baud, w_baud_nxt;
   logic [2:0]           r_bit, w_bit_nxt;
   logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
   logic                 r_par, w_par_nxt;
   logic                 r_tx, r_busy, r_done;
   logic                 w_tick, w_frame_end, w_load, w_line;
   logic [DATA_BITS-1:0] w_word;
   logic                 w_has_word, w_empty;

   assign w_tick      = (r_baud == TICK_VAL);
   assign w_frame_end = (r_state == S_STOP) && w_tick && (r_bit == 3'(STOP_BITS - 1));

`ifdef UART_TX_FIFO_EN
   localparam int DEPTH = 2 ** FIFO_AW;

   logic [DATA_BITS-1:0] r_mem [DEPTH];
   logic [FIFO_AW-1:0]   r_wp, r_rp;
   logic [FIFO_AW:0]     r_cnt;
   logic                 w_push, w_full;

   assign w_full     = (r_cnt == (FIFO_AW + 1)'(DEPTH));
   assign w_empty    = (r_cnt == '0);
   assign ready      = !w_full;
   assign w_push     = valid && !w_full;
   assign w_word     = r_mem[r_rp];
   assign w_has_word = !w_empty;
   // A queued word is taken when idle, or in the frame-end cycle so the next
   // start bit follows the last stop bit with no gap.
   assign w_load     = w_has_word && ((r_state == S_IDLE) || w_frame_end);

   always_ff @(posedge clock_50mhz or posedge reset) begin
      if (reset) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push) r_wp <= r_wp + 1'b1;
         if (w_load) r_rp <= r_rp + 1'b1;
         case ({w_push, w_load})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: ;
         endcase
      end
   end

   // NOTE: storage carries no reset; pointers and count define which entries
   // are valid, so clearing the array would only cost reset fan-out.
   always_ff @(posedge clock_50mhz) begin
      if (w_push) r_mem[r_wp] <= data;
   end
`else
   // FIFO_AW has no role without the queue.
   localparam int FIFO_AW_UNUSED = FIFO_AW;

   // NOTE: ready is gated by reset combinationally so no word can be taken
   // while the framer is held in reset.
   assign ready      = (r_state == S_IDLE) && !reset;
   assign w_empty    = 1'b1;
   assign w_word     = data;
   assign w_has_word = valid;
   assign w_load     = w_has_word && (r_state == S_IDLE);
`endif

   // NOTE: every output of this block gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_baud_nxt  = w_tick ? '0 : r_baud + 1'b1;
      w_bit_nxt   = r_bit;
      w_shift_nxt = r_shift;
      w_par_nxt   = r_par;
      w_line      = 1'b1;

      case (r_state)
         S_IDLE: begin
            w_baud_nxt = '0;
         end
         S_START: begin
            w_line = 1'b0;
            if (w_tick) begin
               w_state_nxt = S_DATA;
               w_bit_nxt   = '0;
            end
         end
         S_DATA: begin
            w_line = r_shift[0];
            if (w_tick) begin
               w_shift_nxt = r_shift >> 1;
               if (r_bit == 3'(DATA_BITS - 1)) begin
                  w_bit_nxt   = '0;
                  w_state_nxt = (PARITY != 0) ? S_PAR : S_STOP;
               end else begin
                  w_bit_nxt = r_bit + 1'b1;
               end
            end
         end
         S_PAR: begin
            w_line = r_par;
            if (w_tick) begin
               w_state_nxt = S_STOP;
               w_bit_nxt   = '0;
            end
         end
         S_STOP: begin
            if (w_frame_end) w_state_nxt = S_IDLE;
            else if (w_tick) w_bit_nxt = r_bit + 1'b1;
         end
         default: w_state_nxt = S_IDLE;
      endcase

      // Loading overrides everything: restart the bit timer and latch the word
      // so the source may change data right after acceptance.
      if (w_load) begin
         w_state_nxt = S_START;
         w_baud_nxt  = '0;
         w_bit_nxt   = '0;
         w_shift_nxt = w_word;
         w_par_nxt   = (PARITY == 1) ? ~^w_word : ^w_word;
      end
   end

   always_ff @(posedge clock_50mhz or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_baud  <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_par   <= 1'b0;
         r_tx    <= 1'b1;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_baud  <= w_baud_nxt;
         r_bit   <= w_bit_nxt;
         r_shift <= w_shift_nxt;
         r_par   <= w_par_nxt;
         r_tx    <= w_line;
         r_busy  <= (r_state != S_IDLE) || !w_empty;
         r_done  <= w_frame_end;
      end
   end

   assign tx_pin = r_tx;
   assign busy   = r_busy;
   assign done   = r_done;

endmodule

// File: tb/tb_uart_tx_frame.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_frame
//   Directed bench for uart_tx_frame. Four instances share one clock:
//     0: DIV=10, 8N1 (FIFO_AW=2 when the FIFO build is used)
//     1: DIV=10, 7 data bits, even parity, 2 stop bits
//     2: DIV=10, 8 data bits, odd parity, 1 stop bit
//     3: defaults, DIV=434
//   Inputs change at negedge (or just after posedge); outputs are sampled at
//   negedge. Sample k is taken in the cycle after the k-th posedge following
//   acceptance.
// -----------------------------------------------------------------------------
module tb_uart_tx_frame;

   localparam int DIV_T = 10;
   localparam int DIV_D = 434;
`ifdef UART_TX_FIFO_EN
   localparam int LAT = 2;   // accept -> pop -> start bit
`else
   localparam int LAT = 1;   // accept -> start bit
`endif
   localparam int MAXC = 1024;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [3:0] valid;
   logic [7:0] d_a, d_c, d_d;
   logic [6:0] d_b;
   wire  [3:0] ready, busy, done, tx;

   logic cap_tx    [MAXC];
   logic cap_done  [MAXC];
   logic cap_busy  [MAXC];
   logic cap_ready [MAXC];

   int vectors = 0;
   int errors  = 0;

   uart_tx_frame #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8),
                   .PARITY(0), .STOP_BITS(1), .FIFO_AW(2)) u_a (
      .clock_50mhz(clk), .reset(rst), .data(d_a), .valid(valid[0]),
      .ready(ready[0]), .busy(busy[0]), .done(done[0]), .tx_pin(tx[0]));

   uart_tx_frame #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(7),
                   .PARITY(2), .STOP_BITS(2), .FIFO_AW(2)) u_b (
      .clock_50mhz(clk), .reset(rst), .data(d_b), .valid(valid[1]),
      .ready(ready[1]), .busy(busy[1]), .done(done[1]), .tx_pin(tx[1]));

   uart_tx_frame #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8),
                   .PARITY(1), .STOP_BITS(1), .FIFO_AW(2)) u_c (
      .clock_50mhz(clk), .reset(rst), .data(d_c), .valid(valid[2]),
      .ready(ready[2]), .busy(busy[2]), .done(done[2]), .tx_pin(tx[2]));

   uart_tx_frame u_d (
      .clock_50mhz(clk), .reset(rst), .data(d_d), .valid(valid[3]),
      .ready(ready[3]), .busy(busy[3]), .done(done[3]), .tx_pin(tx[3]));

   // Offer a word to instance idx and return once it has been accepted
   // (just after the accepting posedge). ok=0 if ready never appeared.
   task automatic accept(input int idx, input logic [7:0] d, output logic ok);
      int n;
      @(negedge clk);
      case (idx)
         0: d_a = d;
         1: d_b = d[6:0];
         2: d_c = d;
         default: d_d = d;
      endcase
      valid[idx] = 1'b1;
      n = 0;
      while (ready[idx] !== 1'b1 && n < 20000) begin
         @(negedge clk);
         n++;
      end
      ok = (ready[idx] === 1'b1);
      @(posedge clk);
      #1 valid[idx] = 1'b0;
   endtask

   task automatic capture(input int idx, input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         cap_tx[k]    = tx[idx];
         cap_done[k]  = done[idx];
         cap_busy[k]  = busy[idx];
         cap_ready[k] = ready[idx];
      end
   endtask

   task automatic test_reset();
      vectors++;
      if (tx !== 4'hF) begin errors++; $display("FAIL rst_tx: got %b want 1111", tx); end
      vectors++;
      if (busy !== 4'h0) begin errors++; $display("FAIL rst_busy: got %b want 0000", busy); end
      vectors++;
      if (done !== 4'h0) begin errors++; $display("FAIL rst_done: got %b want 0000", done); end
      rst = 1'b0;
      @(negedge clk);
      vectors++;
      if (ready !== 4'hF) begin errors++; $display("FAIL rst_ready: got %b want 1111", ready); end
   endtask

   task automatic test_frame_8n1();
      logic exp_bits [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      logic ok, got, busy_ok;
      int   n_done, pos;
      accept(0, 8'hA5, ok);
      vectors++;
      if (!ok) begin errors++; $display("FAIL a5_accept: ready never high"); end
      capture(0, LAT + 10 * DIV_T + 2);
      vectors++;
      if (cap_tx[LAT-1] !== 1'b1) begin errors++; $display("FAIL a5_latency: tx_pin got %b want 1 before start", cap_tx[LAT-1]); end
      for (int b = 0; b < 10; b++) begin
         ok = 1'b1; got = exp_bits[b];
         for (int c = 0; c < DIV_T; c++)
            if (ok && cap_tx[LAT + b*DIV_T + c] !== exp_bits[b]) begin ok = 1'b0; got = cap_tx[LAT + b*DIV_T + c]; end
         vectors++;
         if (!ok) begin errors++; $display("FAIL a5_bit%0d: tx_pin got %b want %b for %0d cycles", b, got, exp_bits[b], DIV_T); end
      end
      n_done = 0; pos = -1;
      for (int k = 0; k < LAT + 10 * DIV_T + 2; k++) if (cap_done[k] === 1'b1) begin n_done++; pos = k; end
      vectors++;
      if (n_done != 1 || pos != LAT - 1 + 100) begin
         errors++; $display("FAIL a5_done: %0d pulses, last at cycle %0d, want 1 at %0d", n_done, pos, LAT - 1 + 100);
      end
      busy_ok = (cap_busy[0] === 1'b0) && (cap_busy[LAT + 100] === 1'b0);
      for (int k = 1; k < LAT + 100; k++) if (cap_busy[k] !== 1'b1) busy_ok = 1'b0;
      vectors++;
      if (!busy_ok) begin errors++; $display("FAIL a5_busy: got wrong window, want high cycles 1..%0d", LAT + 99); end
   endtask

   task automatic test_parity_even();
      // 0x55 in 7 bits: 1,0,1,0,1,0,1 LSB first; four ones -> even parity 0.
      logic exp_bits [11] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      logic ok, got, rdy_ok;
      int   n_done, pos;
      accept(1, 8'h55, ok);
      vectors++;
      if (!ok) begin errors++; $display("FAIL e55_accept: ready never high"); end
      capture(1, LAT + 11 * DIV_T + 2);
      for (int b = 0; b < 11; b++) begin
         ok = 1'b1; got = exp_bits[b];
         for (int c = 0; c < DIV_T; c++)
            if (ok && cap_tx[LAT + b*DIV_T + c] !== exp_bits[b]) begin ok = 1'b0; got = cap_tx[LAT + b*DIV_T + c]; end
         vectors++;
         if (!ok) begin errors++; $display("FAIL e55_bit%0d: tx_pin got %b want %b", b, got, exp_bits[b]); end
      end
      n_done = 0; pos = -1;
      for (int k = 0; k < LAT + 11 * DIV_T + 2; k++) if (cap_done[k] === 1'b1) begin n_done++; pos = k; end
      vectors++;
      if (n_done != 1 || pos != LAT - 1 + 110) begin
         errors++; $display("FAIL e55_length: done %0d pulses at cycle %0d, want 1 at %0d", n_done, pos, LAT - 1 + 110);
      end
      rdy_ok = 1'b1;
`ifdef UART_TX_FIFO_EN
      for (int k = 0; k <= 110; k++) if (cap_ready[k] !== 1'b1) rdy_ok = 1'b0;
`else
      for (int k = 0; k < 110; k++) if (cap_ready[k] !== 1'b0) rdy_ok = 1'b0;
      if (cap_ready[110] !== 1'b1) rdy_ok = 1'b0;
`endif
      vectors++;
      if (!rdy_ok) begin errors++; $display("FAIL e55_ready: got wrong ready window around idle return"); end
   endtask

   task automatic test_parity_odd();
      logic [7:0] words [2] = '{8'h00, 8'h01};
      logic       par_exp [2] = '{1'b1, 1'b0};
      logic ok, got;
      logic [10:0] f;
      for (int w = 0; w < 2; w++) begin
         f = {1'b1, par_exp[w], words[w], 1'b0};
         accept(2, words[w], ok);
         vectors++;
         if (!ok) begin errors++; $display("FAIL odd%0d_accept: ready never high", w); end
         capture(2, LAT + 11 * DIV_T + 2);
         for (int b = 0; b < 11; b++) begin
            ok = 1'b1; got = f[b];
            for (int c = 0; c < DIV_T; c++)
               if (ok && cap_tx[LAT + b*DIV_T + c] !== f[b]) begin ok = 1'b0; got = cap_tx[LAT + b*DIV_T + c]; end
            vectors++;
            if (!ok) begin errors++; $display("FAIL odd_%02h_bit%0d: tx_pin got %b want %b", words[w], b, got, f[b]); end
         end
      end
   endtask

   task automatic test_reset_midframe();
      logic        ok, got, quiet;
      logic [9:0]  f = {1'b1, 8'h3C, 1'b0};
      int          n_done, pos;
      accept(0, 8'hA5, ok);
      vectors++;
      if (!ok) begin errors++; $display("FAIL mid_accept: ready never high"); end
      // Data bit 3 is frame bit 4: cycles LAT+40 .. LAT+49; stop in its middle.
      capture(0, LAT + 45);
      vectors++;
      if (cap_tx[LAT + 44] !== 1'b0) begin errors++; $display("FAIL mid_level: tx_pin got %b want 0 in data bit 3", cap_tx[LAT + 44]); end
      #1 rst = 1'b1;
      #1;
      vectors++;
      if (tx[0] !== 1'b1) begin errors++; $display("FAIL mid_tx: got %b want 1 during reset", tx[0]); end
      vectors++;
      if (busy[0] !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b want 0 during reset", busy[0]); end
      @(negedge clk);
      rst = 1'b0;
      capture(0, 120);
      n_done = 0; quiet = 1'b1;
      for (int k = 0; k < 120; k++) begin
         if (cap_done[k] === 1'b1) n_done++;
         if (cap_tx[k] !== 1'b1) quiet = 1'b0;
      end
      vectors++;
      if (n_done != 0) begin errors++; $display("FAIL mid_no_done: got %0d pulses want 0", n_done); end
      vectors++;
      if (!quiet) begin errors++; $display("FAIL mid_idle_line: tx_pin got 0 after reset want 1"); end
      accept(0, 8'h3C, ok);
      vectors++;
      if (!ok) begin errors++; $display("FAIL post_accept: ready never high"); end
      capture(0, LAT + 10 * DIV_T + 2);
      for (int b = 0; b < 10; b++) begin
         ok = 1'b1; got = f[b];
         for (int c = 0; c < DIV_T; c++)
            if (ok && cap_tx[LAT + b*DIV_T + c] !== f[b]) begin ok = 1'b0; got = cap_tx[LAT + b*DIV_T + c]; end
         vectors++;
         if (!ok) begin errors++; $display("FAIL post3c_bit%0d: tx_pin got %b want %b", b, got, f[b]); end
      end
      n_done = 0; pos = -1;
      for (int k = 0; k < LAT + 10 * DIV_T + 2; k++) if (cap_done[k] === 1'b1) begin n_done++; pos = k; end
      vectors++;
      if (n_done != 1 || pos != LAT - 1 + 100) begin
         errors++; $display("FAIL post3c_done: %0d pulses at cycle %0d, want 1 at %0d", n_done, pos, LAT - 1 + 100);
      end
   endtask

   task automatic test_default_baud();
      logic ok, idle_ok;
      int   first_low, run;
      capture(3, 50);
      idle_ok = 1'b1;
      for (int k = 0; k < 50; k++) if (cap_tx[k] !== 1'b1) idle_ok = 1'b0;
      vectors++;
      if (!idle_ok) begin errors++; $display("FAIL dflt_idle: tx_pin got 0 before handshake want 1"); end
      accept(3, 8'hFF, ok);
      vectors++;
      if (!ok) begin errors++; $display("FAIL dflt_accept: ready never high"); end
      capture(3, LAT + DIV_D + 10);
      first_low = -1; run = 0;
      for (int k = 0; k < LAT + DIV_D + 10; k++) begin
         if (first_low < 0 && cap_tx[k] === 1'b0) first_low = k;
         if (first_low >= 0 && k - first_low == run && cap_tx[k] === 1'b0) run++;
      end
      vectors++;
      if (first_low != LAT) begin errors++; $display("FAIL dflt_start_pos: got cycle %0d want %0d", first_low, LAT); end
      vectors++;
      if (run != DIV_D) begin errors++; $display("FAIL dflt_start_width: got %0d cycles want %0d", run, DIV_D); end
   endtask

`ifdef UART_TX_FIFO_EN
   task automatic test_back_to_back();
      logic [7:0] words [5] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};
      logic [9:0] f;
      logic       ok, got, rdy_ok, busy_ok;
      int         n_done;
      @(negedge clk);
      d_a = words[0];
      valid[0] = 1'b1;
      vectors++;
      if (ready[0] !== 1'b1) begin errors++; $display("FAIL fifo_push0: ready got %b want 1", ready[0]); end
      @(posedge clk);
      for (int k = 0; k < 510; k++) begin
         @(negedge clk);
         cap_tx[k] = tx[0]; cap_done[k] = done[0]; cap_busy[k] = busy[0]; cap_ready[k] = ready[0];
         if (k < 4) begin
            vectors++;
            if (ready[0] !== 1'b1) begin errors++; $display("FAIL fifo_push%0d: ready got %b want 1", k + 1, ready[0]); end
            d_a = words[k + 1];
         end else if (k == 4) begin
            valid[0] = 1'b0;
         end
      end
      rdy_ok = (cap_ready[101] === 1'b1);
      for (int k = 4; k <= 100; k++) if (cap_ready[k] !== 1'b0) rdy_ok = 1'b0;
      vectors++;
      if (!rdy_ok) begin errors++; $display("FAIL fifo_ready: want low cycles 4..100 and high at 101"); end
      for (int w = 0; w < 5; w++) begin
         f = {1'b1, words[w], 1'b0};
         ok = 1'b1; got = 1'b0;
         for (int b = 0; b < 10; b++)
            for (int c = 0; c < DIV_T; c++)
               if (ok && cap_tx[2 + 100*w + b*DIV_T + c] !== f[b]) begin ok = 1'b0; got = cap_tx[2 + 100*w + b*DIV_T + c]; end
         vectors++;
         if (!ok) begin errors++; $display("FAIL fifo_frame%0d: tx_pin got %b, want frame of %02h", w, got, words[w]); end
         vectors++;
         if (cap_done[101 + 100*w] !== 1'b1) begin errors++; $display("FAIL fifo_done%0d: got %b want 1 at %0d", w, cap_done[101 + 100*w], 101 + 100*w); end
      end
      n_done = 0;
      for (int k = 0; k < 510; k++) if (cap_done[k] === 1'b1) n_done++;
      vectors++;
      if (n_done != 5) begin errors++; $display("FAIL fifo_done_count: got %0d want 5", n_done); end
      busy_ok = (cap_busy[502] === 1'b0);
      for (int k = 1; k <= 501; k++) if (cap_busy[k] !== 1'b1) busy_ok = 1'b0;
      vectors++;
      if (!busy_ok) begin errors++; $display("FAIL fifo_busy: want high cycles 1..501, low at 502"); end
   endtask
`endif

   initial begin
      valid = '0;
      d_a = '0; d_b = '0; d_c = '0; d_d = '0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      test_reset();
      test_frame_8n1();
      test_parity_even();
      test_parity_odd();
      test_reset_midframe();
`ifdef UART_TX_FIFO_EN
      test_back_to_back();
`endif
      test_default_baud();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
